// File: rtl/game_pkg.sv
// game_pkg: shared direction/state types, keycodes and tile helpers for game-field blocks
package game_pkg;
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
  typedef enum logic {IDLE = 1'b0, MOVING = 1'b1} mover_state_t;
  localparam logic [7:0] KEY_RIGHT_A = 8'd79, KEY_RIGHT_B = 8'd7;
  localparam logic [7:0] KEY_LEFT_A  = 8'd80, KEY_LEFT_B  = 8'd4;
  localparam logic [7:0] KEY_DOWN_A  = 8'd81, KEY_DOWN_B  = 8'd22;
  localparam logic [7:0] KEY_UP_A    = 8'd82, KEY_UP_B    = 8'd26;
  // returns {valid, dir}
  function automatic logic [2:0] key_decode(input logic [7:0] k);
    return (k == KEY_RIGHT_A || k == KEY_RIGHT_B) ? {1'b1, RIGHT} :
           (k == KEY_LEFT_A  || k == KEY_LEFT_B)  ? {1'b1, LEFT}  :
           (k == KEY_DOWN_A  || k == KEY_DOWN_B)  ? {1'b1, DOWN}  :
           (k == KEY_UP_A    || k == KEY_UP_B)    ? {1'b1, UP}    : 3'b000;
  endfunction
  function automatic logic in_map(input dir_t d, input logic [4:0] tx, input logic [4:0] ty,
                                  input int mw, input int mh);
    return d == UP ? ty != 5'd0 : d == DOWN ? int'(ty) < mh - 1 :
           d == LEFT ? tx != 5'd0 : int'(tx) < mw - 1;
  endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: synchronises an asynchronous frame strobe and emits a one-Clk tick per rising edge
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);
  logic s1, s2, s3;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1 <= frame_clk;
      s2 <= s1;
      s3 <= s2;
      tick <= s2 & ~s3;
    end
endmodule

// File: rtl/grid_mover.sv
// grid_mover: tile-locked character motion controller with is_Char overlay.
// Define GRID_MOVER_QUEUE_EN to add a 1-entry direction queue chaining moves on arrival.
module grid_mover import game_pkg::*; #(
  parameter int COORD_W   = 10,
  parameter int TILE_LOG2 = 5,
  parameter int MAP_W     = 15,
  parameter int MAP_H     = 15,
  parameter int STEP_W    = 4,
  parameter int SPAWN_TX  = 1,
  parameter int SPAWN_TY  = 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic [7:0]         move,
  input  logic               upID,
  input  logic               downID,
  input  logic               leftID,
  input  logic               rightID,
  input  logic [STEP_W-1:0]  Step,
  input  logic               respawn,
  input  logic [4:0]         Spawn_TX,
  input  logic [4:0]         Spawn_TY,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [COORD_W-1:0] Char_X_Pos,
  output logic [COORD_W-1:0] Char_Y_Pos,
  output logic [4:0]         Char_TX,
  output logic [4:0]         Char_TY,
  output dir_t               dir,
  output logic               moving,
  output logic               is_Char
);
  localparam int TILE = 1 << TILE_LOG2;
  localparam int RW = TILE_LOG2 + 1;
  mover_state_t state;
  logic [RW-1:0] rem, d;
  logic [STEP_W-1:0] s1;
  logic [2:0] kd;
  logic [3:0] pass;
  logic [4:0] ntx, nty;
  logic [COORD_W-1:0] dpx, ddx, ddy;
  logic tick, key_v, idle_ok, arrive;
  dir_t key_d;
  frame_tick_sync u_sync (.Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .tick(tick));
  assign kd = key_decode(move);
  assign key_v = kd[2];
  assign key_d = dir_t'(kd[1:0]);
  assign pass = {rightID, leftID, downID, upID};
  assign idle_ok = pass[key_d] && in_map(key_d, Char_TX, Char_TY, MAP_W, MAP_H);
  assign s1 = Step == '0 ? STEP_W'(1) : Step;
  assign d = int'(s1) < int'(rem) ? RW'(s1) : rem;
  assign dpx = COORD_W'(d);
  assign arrive = d == rem;
  // destination tile of the move in progress
  assign ntx = dir == RIGHT ? Char_TX + 5'd1 : dir == LEFT ? Char_TX - 5'd1 : Char_TX;
  assign nty = dir == DOWN ? Char_TY + 5'd1 : dir == UP ? Char_TY - 5'd1 : Char_TY;
  assign ddx = DrawX - Char_X_Pos;
  assign ddy = DrawY - Char_Y_Pos;
  assign is_Char = ddx < COORD_W'(TILE) && ddy < COORD_W'(TILE);
`ifdef GRID_MOVER_QUEUE_EN
  logic q_v, q_ok;
  dir_t q_d;
  assign q_ok = pass[q_d] && in_map(q_d, ntx, nty, MAP_W, MAP_H);
`endif
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      moving <= 1'b0;
      rem <= '0;
      dir <= DOWN;
      Char_TX <= 5'(SPAWN_TX);
      Char_TY <= 5'(SPAWN_TY);
      Char_X_Pos <= COORD_W'(SPAWN_TX * TILE);
      Char_Y_Pos <= COORD_W'(SPAWN_TY * TILE);
`ifdef GRID_MOVER_QUEUE_EN
      q_v <= 1'b0;
      q_d <= DOWN;
`endif
    end else if (respawn) begin
      state <= IDLE;
      moving <= 1'b0;
      rem <= '0;
      dir <= DOWN;
      Char_TX <= Spawn_TX;
      Char_TY <= Spawn_TY;
      Char_X_Pos <= COORD_W'(Spawn_TX) << TILE_LOG2;
      Char_Y_Pos <= COORD_W'(Spawn_TY) << TILE_LOG2;
`ifdef GRID_MOVER_QUEUE_EN
      q_v <= 1'b0;
`endif
    end else if (tick) begin
      if (state == IDLE) begin
        if (key_v) begin
          dir <= key_d;
          if (idle_ok) begin
            state <= MOVING;
            moving <= 1'b1;
            rem <= RW'(TILE);
          end
        end
      end else begin
        Char_X_Pos <= dir == RIGHT ? Char_X_Pos + dpx : dir == LEFT ? Char_X_Pos - dpx : Char_X_Pos;
        Char_Y_Pos <= dir == DOWN ? Char_Y_Pos + dpx : dir == UP ? Char_Y_Pos - dpx : Char_Y_Pos;
        rem <= rem - d;
        if (arrive) begin
          Char_TX <= ntx;
          Char_TY <= nty;
`ifdef GRID_MOVER_QUEUE_EN
          q_v <= 1'b0;
          if (q_v) dir <= q_d;
          if (q_v && q_ok) rem <= RW'(TILE);
          else begin
            state <= IDLE;
            moving <= 1'b0;
          end
`else
          state <= IDLE;
          moving <= 1'b0;
`endif
        end
`ifdef GRID_MOVER_QUEUE_EN
        else if (key_v) begin
          q_v <= 1'b1;
          q_d <= key_d;
        end
`endif
      end
    end
endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed plus randomized checks of grid_mover against a tile-level reference model
module tb_grid_mover;
  import game_pkg::*;
  logic Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0, respawn = 1'b0;
  logic upID = 1'b0, downID = 1'b0, leftID = 1'b0, rightID = 1'b0;
  logic [7:0] move = 8'd0;
  logic [3:0] Step = 4'd4;
  logic [4:0] Spawn_TX = 5'd0, Spawn_TY = 5'd0;
  logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
  logic [9:0] Char_X_Pos, Char_Y_Pos;
  logic [4:0] Char_TX, Char_TY;
  dir_t dir;
  logic moving, is_Char;
  int checks = 0, failures = 0;
  int mx, my, mtx, mty, mdir, mrem;
  bit mmov;
  grid_mover dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .move(move),
    .upID(upID), .downID(downID), .leftID(leftID), .rightID(rightID),
    .Step(Step), .respawn(respawn), .Spawn_TX(Spawn_TX), .Spawn_TY(Spawn_TY),
    .DrawX(DrawX), .DrawY(DrawY), .Char_X_Pos(Char_X_Pos), .Char_Y_Pos(Char_Y_Pos),
    .Char_TX(Char_TX), .Char_TY(Char_TY), .dir(dir), .moving(moving), .is_Char(is_Char)
  );
  always #10 Clk = ~Clk;
  function automatic int key_dir(int k);
    return (k == 79 || k == 7) ? 3 : (k == 80 || k == 4) ? 2 : (k == 81 || k == 22) ? 1 :
           (k == 82 || k == 26) ? 0 : -1;
  endfunction
  function automatic int sx(int d);
    return d == 3 ? 1 : d == 2 ? -1 : 0;
  endfunction
  function automatic int sy(int d);
    return d == 1 ? 1 : d == 0 ? -1 : 0;
  endfunction
  function automatic bit flag(int d);
    return d == 0 ? upID : d == 1 ? downID : d == 2 ? leftID : rightID;
  endfunction
  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic check_all(string tag);
    int ex;
    DrawX = 10'(mx + int'($urandom_range(0, 40)) - 4);
    DrawY = 10'(my + int'($urandom_range(0, 40)) - 4);
    #1;
    ex = (((int'(DrawX) - mx) & 1023) < 32 && ((int'(DrawY) - my) & 1023) < 32) ? 1 : 0;
    chk({tag, ".x"}, int'(Char_X_Pos), mx);
    chk({tag, ".y"}, int'(Char_Y_Pos), my);
    chk({tag, ".tx"}, int'(Char_TX), mtx);
    chk({tag, ".ty"}, int'(Char_TY), mty);
    chk({tag, ".dir"}, int'(dir), mdir);
    chk({tag, ".moving"}, int'(moving), int'(mmov));
    chk({tag, ".is_char"}, int'(is_Char), ex);
  endtask
  task automatic model_reset();
    mx = 32; my = 32; mtx = 1; mty = 1; mdir = 1; mrem = 0; mmov = 0;
  endtask
  task automatic model_tick();
    int kd, nx, ny, st;
    kd = key_dir(int'(move));
    if (!mmov) begin
      if (kd >= 0) begin
        mdir = kd;
        nx = mtx + sx(kd);
        ny = mty + sy(kd);
        if (flag(kd) && nx >= 0 && nx < 15 && ny >= 0 && ny < 15) begin
          mmov = 1;
          mrem = 32;
        end
      end
    end else begin
      st = (Step == 0) ? 1 : int'(Step);
      if (st > mrem) st = mrem;
      mx += sx(mdir) * st;
      my += sy(mdir) * st;
      mrem -= st;
      if (mrem == 0) begin
        mmov = 0;
        mtx += sx(mdir);
        mty += sy(mdir);
      end
    end
  endtask
  task automatic set_in(int k, bit u, bit dn, bit l, bit r, int s);
    @(negedge Clk);
    move = 8'(k); upID = u; downID = dn; leftID = l; rightID = r; Step = 4'(s);
  endtask
  task automatic do_tick(string tag);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    model_tick();
    check_all(tag);
  endtask
  // with_tick lines the respawn pulse up with the internal tick edge
  task automatic respawn_now(int tx, int ty, bit with_tick);
    @(negedge Clk);
    Spawn_TX = 5'(tx); Spawn_TY = 5'(ty);
    if (with_tick) begin
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
    end
    respawn = 1'b1;
    @(negedge Clk);
    respawn = 1'b0;
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    mx = tx * 32; my = ty * 32; mtx = tx; mty = ty; mdir = 1; mrem = 0; mmov = 0;
    check_all(with_tick ? "respawn_tick" : "respawn");
  endtask
  initial begin
    int keys [10] = '{79, 7, 80, 4, 81, 22, 82, 26, 0, 55};
    model_reset();
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    check_all("reset");
    set_in(79, 0, 0, 0, 1, 4);
    repeat (9) do_tick("right4");
    set_in(80, 0, 0, 1, 0, 5);
    repeat (8) do_tick("left5");
    set_in(81, 0, 1, 0, 0, 0);
    repeat (33) do_tick("down0");
    set_in(82, 0, 1, 1, 1, 4);
    do_tick("blocked_up");
    respawn_now(0, 0, 0);
    set_in(80, 1, 1, 1, 1, 4);
    do_tick("edge_left");
    set_in(82, 1, 1, 1, 1, 4);
    do_tick("edge_up");
    set_in(79, 1, 1, 1, 1, 15);
    repeat (5) do_tick("chain_no_queue");
    set_in(79, 1, 1, 1, 1, 8);
    repeat (2) do_tick("pre_respawn");
    set_in(0, 1, 1, 1, 1, 8);
    respawn_now(3, 4, 1);
    set_in(81, 1, 1, 1, 1, 8);
    repeat (2) do_tick("pre_reset");
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_reset();
    check_all("async_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) respawn_now(int'($urandom_range(0, 14)), int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
      else begin
        set_in(keys[$urandom_range(0, 9)], $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
        do_tick("random");
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grid_mover.md
# grid_mover

Parametrised, tile-locked character motion controller for the map-based game field. It accepts a keyboard move code and per-direction passability flags, and moves the character one full tile per accepted command in `Step`-pixel increments, one increment per frame. It reports pixel position, tile index, facing and busy status, and provides the `is_char` overlay for the pixel pipeline. It sits between the keycode decoder and map/passability lookup on one side, and the sprite/colour mapper on the other.

## Interface
Parameters:
- `COORD_W`, 10: pixel coordinate width.
- `TILE_LOG2`, 5: log2 of tile edge in pixels (TILE = 32).
- `MAP_W`, 15: map width in tiles.
- `MAP_H`, 15: map height in tiles.
- `STEP_W`, 4: width of `Step`.
- `SPAWN_TX`, 1: reset tile column.
- `SPAWN_TY`, 1: reset tile row.

Ports:
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `frame_clk` in 1: ~60 Hz frame strobe, asynchronous to `Clk`.
- `move` in 8: keycode. Right = 79/7, left = 80/4, down = 81/22, up = 82/26; any other value means none.
- `upID`, `downID`, `leftID`, `rightID` in 1 each: 1 = neighbouring tile in that direction is passable.
- `Step` in STEP_W: pixels per frame. 0 is treated as 1.
- `respawn` in 1: 1-cycle pulse that returns the character to `Spawn_TX`/`Spawn_TY`.
- `Spawn_TX`, `Spawn_TY` in 5 each: runtime respawn tile.
- `DrawX`, `DrawY` in COORD_W: current pixel coordinates.
- `Char_X_Pos`, `Char_Y_Pos` out COORD_W: top-left pixel of the character.
- `Char_TX`, `Char_TY` out 5: tile currently occupied (the source tile while moving).
- `dir` out 2: facing, encoded with `dir_t`.
- `moving` out 1: high while in MOVING.
- `is_Char` out 1: combinational; high when the current pixel is inside the character square.

## Operation
- **Frame tick**
  - `frame_clk` passes through a 2-flop synchroniser, then a rising-edge detector.
  - The result is `tick`, one `Clk` cycle wide.
- **FSM states**
  - IDLE: position is tile-aligned.
  - MOVING: `rem` counts pixels still to travel.
- **IDLE on `tick` with a valid `move`:**
  - `dir` takes the key's direction, regardless of whether the move is accepted.
  - The move is accepted only if:
    - the direction's passability flag is 1, and
    - the target tile is in range: 0..MAP_W-1 for columns, 0..MAP_H-1 for rows.
  - On acceptance, load `rem` = TILE and go to MOVING. No pixel moves on this tick.
  - On rejection, stay in IDLE.
- **MOVING on `tick`:**
  - Compute `d` = min(max(`Step`, 1), `rem`).
  - Update position by ±`d` and set `rem` = `rem` − `d`.
  - When `rem` reaches 0:
    - go to IDLE;
    - update `Char_TX`/`Char_TY` to the target tile;
    - position equals the target tile × TILE exactly.
  - `move` and the passability flags are ignored while MOVING (see Configuration for the exception).
- **`respawn`:**
  - From any state, go to IDLE.
  - Position = `Spawn_T*` × TILE; tile outputs = `Spawn_T*`; `dir` = DOWN.
  - `respawn` wins over a simultaneous `tick`.
- **`is_Char`:** (`DrawX` − `Char_X_Pos`) < TILE and (`DrawY` − `Char_Y_Pos`) < TILE, using unsigned COORD_W-bit wraparound subtraction.
- **Arithmetic:** all pixel arithmetic is COORD_W bits. Because targets are range-checked, position never under- or overflows.

## Timing
- Reset values:
  - state = IDLE, `moving` = 0, `rem` = 0, `dir` = DOWN;
  - `Char_TX` = SPAWN_TX, `Char_TY` = SPAWN_TY;
  - position = SPAWN × TILE;
  - synchroniser and edge flops = 0.
- `tick` asserts 3 `Clk` cycles after `frame_clk` rises: 2 synchroniser cycles plus 1 edge-detect cycle.
- All state, position and `dir` updates happen on the `Clk` edge where `tick` = 1 and are visible the next cycle.
- `respawn` takes effect on the next `Clk` edge.
- `is_Char` has zero latency relative to `DrawX`/`DrawY` and the registered position.
- A full tile at `Step` = s takes 1 + ceil(32/s) ticks: the accept tick plus the motion ticks.
- Deasserting `Reset_n` mid-move restores the reset values immediately (asynchronous); no partial tile is retained.

## Configuration
- **`GRID_MOVER_QUEUE_EN` defined:**
  - A 1-entry direction queue is added.
  - The last valid `move` seen on a MOVING `tick` is latched.
  - On the arrival tick, if the queue is valid, the queued move is evaluated immediately against the new tile's flags, as if in IDLE. If accepted, `moving` stays high with no idle tick.
  - The queue clears on arrival, on `respawn` and on reset.
- **Undefined:** no queue. Moves are evaluated only in IDLE.

## Structure
- Package `game_pkg` holds:
  - `dir_t` (UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3);
  - the keycode constants;
  - the `mover_state_t` enum.
- Sub-module `frame_tick_sync` contains the synchroniser and edge detector. It is reusable by other frame-paced blocks.

## Test plan
- **Reset and right move:** reset, then hold `move` = 79 with `rightID` = 1 and `Step` = 4.
  - Required: accept tick, then 8 ticks.
  - `Char_X_Pos` goes 32 → 64 in steps of 4; `Char_TX` goes 1 → 2 at the last tick; `moving` falls.
- **Non-divisor step:** `Step` = 5, move left from tile 2.
  - Required: X = 64, 59, 54, 49, 44, 39, 34, 32 (last step clamped to 2).
  - `Step` = 0 behaves as 1.
- **Blocked and edge moves:**
  - `move` = 82 with `upID` = 0: `dir` = UP, position unchanged, `moving` = 0.
  - Left move at `Char_TX` = 0 with `leftID` = 1: rejected.
- **Respawn mid-move:** `respawn` pulsed on the same cycle as `tick` in MOVING, with `Spawn_TX`/`Spawn_TY` = 3, 4.
  - Required: position = (96, 128), IDLE, `dir` = DOWN.
- **Async reset:** drop `Reset_n` mid-move, between ticks.
  - Required: outputs return to the reset values within the same cycle.
- **Queue (`GRID_MOVER_QUEUE_EN`):** press down during a right move.
  - Required: the down move starts on the arrival tick with `moving` continuously high.
  - Without the macro, the next move requires a further IDLE tick.
